sym2_deframer: RTL and testbench
================================

# sym2_deframer

Receive-side companion to the team's 2-bit symbol producers. It samples a 2-bit symbol stream on `clk` and hunts for a sync byte. Once locked, it packs every four symbols MSB-first into a byte and queues the bytes in a small first-word-fall-through FIFO, which a downstream consumer drains through a valid/ready handshake. It sits between any 2-bit symbol source and byte-wide logic, and flags lock status and dropped bytes.

## Interface
- `FIFO_DEPTH`, 4: byte FIFO depth; power of two, ≥2.
- `SYNC_BYTE`, 8'hFC: framing pattern (symbols 3,3,3,0).
- `clk`  in  1  single clock; all state updates on posedge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sym_valid`  in  1  `sym` carries a symbol this cycle.
- `sym`  in  2  received symbol.
- `resync`  in  1  synchronous request to drop lock and re-hunt.
- `byte_valid`  out  1  FIFO non-empty.
- `byte_data`  out  8  FIFO head byte (first-word fall-through).
- `byte_ready`  in  1  consumer accepts head this cycle.
- `locked`  out  1  framing acquired.
- `overflow`  out  1  sticky: a byte was dropped because the FIFO was full.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  bytes held.

## Operation
- States are HUNT and LOCKED. Reset enters HUNT.
- **HUNT** (driven by `sym_valid` cycles only):
  - Update `shreg <= {shreg[5:0], sym}`.
  - Increment `hunt_cnt`, saturating at 4.
  - If the post-shift value equals `SYNC_BYTE` and `hunt_cnt` (post-increment) is ≥4, go to LOCKED with `phase=0`.
  - The sync byte is not queued.
- **LOCKED**:
  - Each `sym_valid` updates `asm <= {asm[5:0], sym}` and increments `phase` mod 4.
  - On `phase==3`, push `{asm[5:0], sym}` to the FIFO.
  - Cycles with `sym_valid=0` change nothing. Gaps of any length are allowed mid-byte.
- **FIFO push/pop**:
  - A pop occurs when `byte_valid && byte_ready`.
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle. Otherwise the byte is discarded and `overflow` is set.
  - Simultaneous push and pop on an empty FIFO: the push is accepted and no pop occurs (`byte_valid` was 0).
  - Pointers wrap modulo `FIFO_DEPTH`. `fifo_count` is 0..`FIFO_DEPTH`.
- **resync** (highest priority, sampled at posedge):
  - Go to HUNT; clear `phase`, `asm`, `shreg` and `hunt_cnt`; clear `overflow`.
  - Any symbol presented in the same cycle is discarded.
  - FIFO contents and pop behaviour are unaffected. Bytes already framed remain valid.
- `locked` is 1 exactly when the state is LOCKED. The block never self-unlocks; only `resync` or reset drops lock.

## Timing
- **Reset values**:
  - `locked=0`, `byte_valid=0`, `byte_data=8'h00` (memory cleared), `overflow=0`, `fifo_count=0`.
  - Internal state: HUNT, `phase=0`, `shreg=0`, `asm=0`, `hunt_cnt=0`.
- **Reset mid-operation**: all of the above take effect immediately and asynchronously. A partial byte is lost.
- **Lock latency**: the final sync symbol sampled at edge N gives `locked=1` after edge N.
- **Byte latency**: the 4th data symbol sampled at edge N, with the FIFO empty, gives `byte_valid=1` and the byte on `byte_data` after edge N.
- **Pop**: at the edge where `byte_valid && byte_ready`, the head advances. `byte_data` shows the next entry after that edge, or `byte_valid` drops if the FIFO is now empty.
- **Full throughput**: one symbol per cycle yields one byte per 4 cycles. With `byte_ready` held high, the FIFO never exceeds 1 entry.
- **Overflow**: `overflow` rises after the edge of the rejected push and holds until reset or `resync`.
- `byte_data` is don't-care while `byte_valid=0`, except after reset.

## Test plan
- **Lock then byte**: after reset, symbols 3,3,3,0 -> `locked=1` after the 4th. Then 1,2,3,0 -> `byte_valid=1`, `byte_data=8'h6C`, `fifo_count=1`.
- **No false lock**: a constant stream of symbol 3 for 50 cycles -> `locked` stays 0. Then 0 -> `locked=1`.
- **Overflow**: lock, `byte_ready=0`, send 5 bytes (0x11, 0x22, 0x33, 0x44, 0x55):
  - -> `fifo_count=4`, `overflow=1` after the 5th.
  - Raising `byte_ready` pops 0x11, 0x22, 0x33, 0x44, then `byte_valid=0`.
- **Gaps and simultaneous push/pop**:
  - Symbols of 0xA5 with random `sym_valid` gaps -> one byte 0xA5.
  - Full FIFO with push and pop on the same edge -> push accepted, `fifo_count` stays 4, `overflow` stays 0.
- **resync mid-byte**: locked, 2 symbols sent, pulse `resync` with `sym_valid=1`:
  - -> `locked=0`, `overflow` cleared, queued bytes still poppable.
  - Re-sync with 3,3,3,0, then 2,2,2,2 -> byte 8'hAA.
- **Async reset**: assert `rst_n=0` between edges while locked with 2 bytes queued -> outputs immediately `locked=0`, `byte_valid=0`, `fifo_count=0`, `overflow=0`.

Source files
------------

// File: rtl/sym2_deframer.sv
// 2-bit symbol deframer: hunts for a sync byte, then packs four symbols MSB-first
// into bytes queued in a first-word-fall-through FIFO with a valid/ready drain.
module sym2_deframer #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] SYNC_BYTE  = 8'hFC
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sym_valid,
  input  logic [1:0]                    sym,
  input  logic                          resync,
  output logic                          byte_valid,
  output logic [7:0]                    byte_data,
  input  logic                          byte_ready,
  output logic                          locked,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t          state, state_nx;
  logic [7:0]      shreg, shreg_nx;
  logic [7:0]      asm_q, asm_nx;
  logic [2:0]      hunt_cnt, hunt_nx;
  logic [1:0]      phase, phase_nx;
  logic            push;
  logic [7:0]      push_byte;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            ovf_q;
  logic            pop, full, accept;

  always_comb begin
    state_nx  = state;
    shreg_nx  = shreg;
    hunt_nx   = hunt_cnt;
    asm_nx    = asm_q;
    phase_nx  = phase;
    push      = 1'b0;
    push_byte = {asm_q[5:0], sym};
    if (resync) begin
      // resync wins over any symbol presented in the same cycle
      state_nx = HUNT;
      shreg_nx = '0;
      hunt_nx  = '0;
      asm_nx   = '0;
      phase_nx = '0;
    end else if (sym_valid) begin
      unique case (state)
        HUNT: begin
          shreg_nx = {shreg[5:0], sym};
          hunt_nx  = (hunt_cnt == 3'd4) ? 3'd4 : hunt_cnt + 3'd1;
          if (shreg_nx == SYNC_BYTE && hunt_nx == 3'd4) begin
            state_nx = LOCKED;
            phase_nx = '0;
          end
        end
        LOCKED: begin
          asm_nx   = {asm_q[5:0], sym};
          phase_nx = phase + 2'd1;
          push     = (phase == 2'd3);
        end
        default: state_nx = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HUNT;
      shreg    <= '0;
      hunt_cnt <= '0;
      asm_q    <= '0;
      phase    <= '0;
    end else begin
      state    <= state_nx;
      shreg    <= shreg_nx;
      hunt_cnt <= hunt_nx;
      asm_q    <= asm_nx;
      phase    <= phase_nx;
    end
  end

  // A full FIFO still takes a push when the head is leaving on the same edge.
  assign pop    = byte_valid && byte_ready;
  assign full   = (count == CW'(FIFO_DEPTH));
  assign accept = push && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= push_byte;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(accept) - CW'(pop);
      if (resync)              ovf_q <= 1'b0;
      else if (push && !accept) ovf_q <= 1'b1;
    end
  end

  assign byte_valid = (count != '0);
  assign byte_data  = mem[rd_ptr];
  assign fifo_count = count;
  assign locked     = (state == LOCKED);
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_sym2_deframer.sv
// Self-checking bench for sym2_deframer: directed test-plan steps plus a random
// phase, all compared against a queue-based reference model of the framing rules.
module tb_sym2_deframer;

  localparam int         DEPTH = 4;
  localparam logic [7:0] SYNC  = 8'hFC;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sym_valid = 1'b0;
  logic [1:0] sym = 2'd0;
  logic       resync = 1'b0;
  logic       byte_ready = 1'b0;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       locked;
  logic       overflow;
  logic [$clog2(DEPTH):0] fifo_count;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // reference model state
  bit          m_locked;
  bit          m_ovf;
  int unsigned m_hist[$];
  int unsigned m_syms[$];
  logic [7:0]  m_fifo[$];

  sym2_deframer #(.FIFO_DEPTH(DEPTH), .SYNC_BYTE(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .sym_valid(sym_valid), .sym(sym), .resync(resync),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .locked(locked), .overflow(overflow), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ":locked"}, 32'(locked), 32'(m_locked));
    checkVal({tag, ":valid"}, 32'(byte_valid), 32'(m_fifo.size() > 0));
    checkVal({tag, ":count"}, 32'(fifo_count), 32'(m_fifo.size()));
    checkVal({tag, ":ovf"}, 32'(overflow), 32'(m_ovf));
    if (m_fifo.size() > 0) checkVal({tag, ":data"}, 32'(byte_data), 32'(m_fifo[0]));
  endtask

  task automatic modelClear();
    m_locked = 0;
    m_ovf    = 0;
    m_hist.delete();
    m_syms.delete();
    m_fifo.delete();
  endtask

  // Drives one cycle of inputs, advances the model, then samples 1 ns after the edge.
  task automatic applyStimulus(input bit v, input logic [1:0] s, input bit rs, input bit rdy);
    bit do_pop, have_push;
    logic [7:0] pb;
    sym_valid  = v;
    sym        = s;
    resync     = rs;
    byte_ready = rdy;
    do_pop     = (m_fifo.size() > 0) && rdy;
    have_push  = 0;
    pb         = '0;
    if (rs) begin
      m_locked = 0;
      m_ovf    = 0;
      m_hist.delete();
      m_syms.delete();
    end else if (v) begin
      if (!m_locked) begin
        m_hist.push_back(int'(s));
        if (m_hist.size() > 4) void'(m_hist.pop_front());
        if (m_hist.size() == 4 &&
            m_hist[0] * 64 + m_hist[1] * 16 + m_hist[2] * 4 + m_hist[3] == int'(SYNC)) begin
          m_locked = 1;
          m_syms.delete();
        end
      end else begin
        m_syms.push_back(int'(s));
        if (m_syms.size() == 4) begin
          pb = 8'(m_syms[0] * 64 + m_syms[1] * 16 + m_syms[2] * 4 + m_syms[3]);
          have_push = 1;
          m_syms.delete();
        end
      end
    end
    if (do_pop) void'(m_fifo.pop_front());
    if (have_push) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back(pb);
      else m_ovf = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b, input bit rdy);
    for (int i = 3; i >= 0; i--) applyStimulus(1, b[i*2 +: 2], 0, rdy);
  endtask

  task automatic sendSync();
    sendByte(SYNC, 0);
  endtask

  task automatic drainAll();
    for (int i = 0; i <= DEPTH && m_fifo.size() > 0; i++) applyStimulus(0, 2'd0, 0, 1);
  endtask

  initial begin
    logic [7:0] exp_bytes [5];
    logic [7:0] b;
    exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    // reset
    modelClear();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset");
    checkVal("reset_data", 32'(byte_data), 32'h00);

    // lock then byte 0x6C
    applyStimulus(1, 2'd3, 0, 0); checkOutput("sync1");
    applyStimulus(1, 2'd3, 0, 0); checkOutput("sync2");
    applyStimulus(1, 2'd3, 0, 0); checkOutput("sync3");
    applyStimulus(1, 2'd0, 0, 0); checkOutput("sync4");
    checkVal("lock_after_sync", 32'(locked), 32'd1);
    sendByte(8'h6C, 0);
    checkOutput("byte6c");
    checkVal("byte6c_data", 32'(byte_data), 32'h6C);
    checkVal("byte6c_count", 32'(fifo_count), 32'd1);
    applyStimulus(0, 2'd0, 0, 1); checkOutput("pop6c");

    // no false lock on a run of 3s
    applyStimulus(0, 2'd0, 1, 0); checkOutput("resync1");
    for (int i = 0; i < 50; i++) begin
      applyStimulus(1, 2'd3, 0, 0);
      checkVal("nolock", 32'(locked), 32'd0);
    end
    applyStimulus(1, 2'd0, 0, 0);
    checkVal("lock_after_run", 32'(locked), 32'd1);

    // overflow
    for (int i = 0; i < 5; i++) sendByte(exp_bytes[i], 0);
    checkOutput("ovf_fill");
    checkVal("ovf_count", 32'(fifo_count), 32'd4);
    checkVal("ovf_flag", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) begin
      checkVal("ovf_pop_data", 32'(byte_data), 32'(exp_bytes[i]));
      applyStimulus(0, 2'd0, 0, 1);
      checkOutput("ovf_pop");
    end
    checkVal("ovf_empty", 32'(byte_valid), 32'd0);

    // gaps, then simultaneous push/pop on a full FIFO
    applyStimulus(0, 2'd0, 1, 0);
    checkVal("ovf_cleared", 32'(overflow), 32'd0);
    sendSync();
    b = 8'hA5;
    for (int i = 3; i >= 0; i--) begin
      for (int g = $urandom_range(0, 3); g > 0; g--) applyStimulus(0, 2'($urandom_range(0, 3)), 0, 0);
      applyStimulus(1, b[i*2 +: 2], 0, 0);
    end
    checkOutput("gap");
    checkVal("gap_data", 32'(byte_data), 32'hA5);
    checkVal("gap_count", 32'(fifo_count), 32'd1);
    sendByte(8'h01, 0);
    sendByte(8'h02, 0);
    sendByte(8'h03, 0);
    b = 8'h04;
    for (int i = 3; i >= 0; i--) applyStimulus(1, b[i*2 +: 2], 0, i == 0);
    checkOutput("pushpop");
    checkVal("pushpop_count", 32'(fifo_count), 32'd4);
    checkVal("pushpop_ovf", 32'(overflow), 32'd0);
    checkVal("pushpop_head", 32'(byte_data), 32'h01);

    // resync mid-byte
    applyStimulus(1, 2'd0, 0, 0);
    applyStimulus(1, 2'd1, 0, 0);
    applyStimulus(1, 2'd3, 1, 0);
    checkOutput("resync_mid");
    checkVal("resync_unlock", 32'(locked), 32'd0);
    checkVal("resync_keep", 32'(fifo_count), 32'd4);
    applyStimulus(0, 2'd0, 0, 1); checkOutput("resync_pop1");
    applyStimulus(0, 2'd0, 0, 1); checkOutput("resync_pop2");
    sendSync();
    sendByte(8'hAA, 0);
    checkOutput("relock_aa");
    checkVal("head_03", 32'(byte_data), 32'h03);
    applyStimulus(0, 2'd0, 0, 1);
    applyStimulus(0, 2'd0, 0, 1);
    checkVal("head_aa", 32'(byte_data), 32'hAA);
    applyStimulus(0, 2'd0, 0, 1);
    checkOutput("drained");

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                    $urandom_range(0, 79) == 0, $urandom_range(0, 2) == 0);
      checkOutput("rand");
      if (i % 100 == 50) begin
        sendSync();
        checkOutput("rand_sync");
      end
    end

    // asynchronous reset between edges
    drainAll();
    applyStimulus(0, 2'd0, 1, 0);
    sendSync();
    sendByte(8'h12, 0);
    sendByte(8'h34, 0);
    checkOutput("pre_areset");
    checkVal("pre_areset_count", 32'(fifo_count), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    modelClear();
    checkVal("areset_locked", 32'(locked), 32'd0);
    checkVal("areset_valid", 32'(byte_valid), 32'd0);
    checkVal("areset_count", 32'(fifo_count), 32'd0);
    checkVal("areset_ovf", 32'(overflow), 32'd0);
    checkVal("areset_data", 32'(byte_data), 32'h00);
    @(negedge clk) rst_n = 1'b1;
    applyStimulus(0, 2'd0, 0, 0);
    checkOutput("post_areset");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
